// File: rtl/mux_grant_pkg.sv
// Shared types and default constants for the two-requester grant controller.
package mux_grant_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } grant_state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int HOLD_CNT_W   = 8;

endpackage

// File: rtl/grant_hold_cnt.sv
// Saturating up-counter measuring how long the current grant has been held.
module grant_hold_cnt
  import mux_grant_pkg::*;
#(
  parameter int CNT_W = HOLD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_grant_ctrl.sv
// Two-requester shared-path arbiter with fair tie-break, hold-time preemption
// and a registered output mux.
//
// state   | meaning
// IDLE    | no grant, data_out holds its last value
// GRANT_A | requester A owns the path, data_out loads data_a
// GRANT_B | requester B owns the path, data_out loads data_b
module mux_grant_ctrl
  import mux_grant_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             done_a,
  input  logic             done_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             sel_a,
  output logic             sel_b,
  output logic             latch_enable,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

  grant_state_e          state;
  grant_state_e          next_state;
  logic                  last_win_a;
  logic                  grant_entry;
  logic [HOLD_CNT_W-1:0] hold_count;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          next_state = last_win_a ? GRANT_B : GRANT_A;
        end else if (req_a) begin
          next_state = GRANT_A;
        end else if (req_b) begin
          next_state = GRANT_B;
        end
      end
      GRANT_A: begin
        if (done_a || !req_a || ((hold_count == HOLD_LIMIT) && req_b)) begin
          next_state = req_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (done_b || !req_b || ((hold_count == HOLD_LIMIT) && req_a)) begin
          next_state = req_a ? GRANT_A : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A->A or B->B without passing through IDLE cannot happen, so a state change
  // into a grant state is exactly a new grant.
  assign grant_entry = (next_state != IDLE) && (next_state != state);

  grant_hold_cnt #(
    .CNT_W(HOLD_CNT_W)
  ) u_hold_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_entry),
    .enable (state != IDLE),
    .limit  (HOLD_LIMIT),
    .count  (hold_count)
  );

  // Outputs are registered copies of the next state so sel_a/sel_b can never
  // overlap, and reset clears them all without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_win_a   <= 1'b0;
      sel_a        <= 1'b0;
      sel_b        <= 1'b0;
      latch_enable <= 1'b0;
      busy         <= 1'b0;
      data_out     <= '0;
    end else begin
      state        <= next_state;
      sel_a        <= (next_state == GRANT_A);
      sel_b        <= (next_state == GRANT_B);
      latch_enable <= (next_state != IDLE);
      busy         <= (next_state != IDLE);
      if (grant_entry) begin
        last_win_a <= (next_state == GRANT_A);
      end
      if (state == GRANT_A) begin
        data_out <= data_a;
      end else if (state == GRANT_B) begin
        data_out <= data_b;
      end
    end
  end

endmodule

// File: tb/tb_mux_grant_ctrl.sv
// Scenario tests plus randomized traffic checked against a rule-level model.
module tb_mux_grant_ctrl;

  localparam int W  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b, done_a, done_b;
  logic [W-1:0] data_a, data_b;
  logic         sel_a, sel_b, latch_enable, busy;
  logic [W-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  // model: owner 0=none 1=A 2=B
  int           m_owner;
  int           m_held;
  int           m_last;
  logic [W-1:0] m_data;

  mux_grant_ctrl #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_a        (req_a),
    .req_b        (req_b),
    .done_a       (done_a),
    .done_b       (done_b),
    .data_a       (data_a),
    .data_b       (data_b),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .latch_enable (latch_enable),
    .data_out     (data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = 0;
    m_held  = 0;
    m_last  = 2;
    m_data  = '0;
  endfunction

  function automatic void model_step();
    int nxt;
    logic mine_req, mine_done, other_req;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
    end else begin
      mine_req  = (m_owner == 1) ? req_a  : req_b;
      mine_done = (m_owner == 1) ? done_a : done_b;
      other_req = (m_owner == 1) ? req_b  : req_a;
      if (!mine_req || mine_done || (other_req && (m_held + 1 >= MH)))
        nxt = other_req ? (3 - m_owner) : 0;
      m_data = (m_owner == 1) ? data_a : data_b;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_held = 0;
      m_last = nxt;
    end else if (nxt != 0 && m_held + 1 < MH) begin
      m_held = m_held + 1;
    end
    m_owner = nxt;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_a = 0; req_b = 0; done_a = 0; done_b = 0;
    data_a = '0; data_b = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({sel_a, sel_b, latch_enable, busy} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {sel_a, sel_b, latch_enable, busy});
    else n_pass++;
    n_checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %h want 0", data_out);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({sel_a, sel_b, busy} !== 3'b000)
      $display("FAIL reset_idle_after_release: got %b want 000", {sel_a, sel_b, busy});
    else n_pass++;
  endtask

  task automatic test_single();
    int bad = 0;
    apply_reset();
    req_a = 1; data_a = 4'hA;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (sel_a !== 1'b1 || latch_enable !== 1'b1 || data_out !== ((c >= 2) ? 4'hA : 4'h0)) begin
        bad++;
        $display("FAIL single_cycle%0d: sel_a=%b le=%b data_out=%h want 1 1 %h",
                 c, sel_a, latch_enable, data_out, (c >= 2) ? 4'hA : 4'h0);
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    done_a = 1;
    tick();
    n_checks++;
    if ({sel_a, latch_enable, busy} !== 3'b000 || data_out !== 4'hA)
      $display("FAIL single_release: sel/le/busy=%b data_out=%h want 000 a",
               {sel_a, latch_enable, busy}, data_out);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_tie();
    apply_reset();
    req_a = 1; req_b = 1;
    tick();
    n_checks++;
    if ({sel_a, sel_b} !== 2'b10) $display("FAIL tie_first: got %b want 10", {sel_a, sel_b});
    else n_pass++;
    done_a = 1;
    tick();
    n_checks++;
    if ({sel_a, sel_b} !== 2'b01) $display("FAIL tie_handoff: got %b want 01", {sel_a, sel_b});
    else n_pass++;
    done_a = 0; req_a = 0; done_b = 1;
    tick();
    done_b = 0; req_b = 0; req_a = 1;
    tick();
    n_checks++;
    if ({sel_a, sel_b} !== 2'b10) $display("FAIL tie_single_a: got %b want 10", {sel_a, sel_b});
    else n_pass++;
    req_a = 0;
    tick();
    req_a = 1; req_b = 1;
    tick();
    n_checks++;
    if ({sel_a, sel_b} !== 2'b01) $display("FAIL tie_second: got %b want 01", {sel_a, sel_b});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_preempt();
    int a_cycles = 0;
    int overlap  = 0;
    bit got_b    = 0;
    apply_reset();
    req_a = 1; req_b = 1;
    for (int c = 0; c < 20 && !got_b; c++) begin
      tick();
      if (sel_a && sel_b) overlap++;
      if (sel_a) a_cycles++;
      if (sel_b) got_b = 1;
    end
    n_checks++;
    if (!got_b) $display("FAIL preempt_timeout: sel_b never rose within 20 cycles");
    else n_pass++;
    n_checks++;
    if (a_cycles != MH) $display("FAIL preempt_len: got %0d want %0d", a_cycles, MH);
    else n_pass++;
    n_checks++;
    if (overlap != 0) $display("FAIL preempt_onehot: got %0d overlaps want 0", overlap);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_no_contention();
    int dropped = 0;
    apply_reset();
    req_a = 1; data_a = 4'h3;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (sel_a !== 1'b1 || sel_b !== 1'b0) dropped++;
    end
    n_checks++;
    if (dropped != 0) $display("FAIL nocont_hold: got %0d bad cycles want 0", dropped);
    else n_pass++;
    n_checks++;
    if (dut.u_hold_cnt.count !== 8'(MH - 1))
      $display("FAIL nocont_sat: got %0d want %0d", dut.u_hold_cnt.count, MH - 1);
    else n_pass++;
  endtask

  task automatic test_stray_done();
    int bad = 0;
    done_b = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (sel_a !== 1'b1 || sel_b !== 1'b0 || data_out !== 4'h3) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stray_done: got %0d disturbed cycles want 0", bad);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_b = 1; data_b = 4'h5;
    tick();
    tick();
    n_checks++;
    if (sel_b !== 1'b1 || data_out !== 4'h5)
      $display("FAIL rstmid_setup: sel_b=%b data_out=%h want 1 5", sel_b, data_out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sel_a, sel_b, latch_enable, busy} !== 4'b0000 || data_out !== '0)
      $display("FAIL rstmid_async: ctrl=%b data_out=%h want 0000 0",
               {sel_a, sel_b, latch_enable, busy}, data_out);
    else n_pass++;
    model_reset();
    @(negedge clk);
    clear_inputs();
    req_a = 1;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({sel_a, sel_b} !== 2'b10) $display("FAIL rstmid_regrant: got %b want 10", {sel_a, sel_b});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    int bad = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_a  = ($urandom_range(0, 99) < 75);
      req_b  = ($urandom_range(0, 99) < 75);
      done_a = ($urandom_range(0, 99) < 12);
      done_b = ($urandom_range(0, 99) < 12);
      data_a = W'($urandom);
      data_b = W'($urandom);
      tick();
      if (sel_a !== (m_owner == 1) || sel_b !== (m_owner == 2) ||
          latch_enable !== (m_owner != 0) || busy !== (m_owner != 0) ||
          data_out !== m_data || (sel_a && sel_b)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_c%0d: sel=%b%b le=%b busy=%b data=%h want owner=%0d data=%h",
                   c, sel_a, sel_b, latch_enable, busy, data_out, m_owner, m_data);
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_tie();
    test_preempt();
    test_no_contention();
    test_stray_done();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
